// File: rtl/dsm_interp_if.sv
// rtl/dsm_interp_if.sv - sample input stream and DAC-side output bundle for dsm_interp
interface dsm_interp_if;
  logic signed [15:0] s_data;
  logic               s_valid;
  logic               s_ready;
  logic               underrun_clr;
  logic signed [15:0] dout;
  logic               cke_out;
  logic               underrun;

  modport master (
    output s_data, s_valid, underrun_clr,
    input  s_ready, dout, cke_out, underrun
  );

  modport slave (
    input  s_data, s_valid, underrun_clr,
    output s_ready, dout, cke_out, underrun
  );
endinterface

// File: rtl/dsm_interp.sv
// rtl/dsm_interp.sv - linear-interpolating upsampler and cke generator for the delta-sigma DAC
module dsm_interp #(
  parameter int DIV      = 4,
  parameter int OSR_LOG2 = 6
) (
  input logic         clk,
  input logic         rst,
  dsm_interp_if.slave bus
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW = 18 + OSR_LOG2;

  logic [DW-1:0]       div_cnt_q, div_cnt_d;
  logic [OSR_LOG2-1:0] phase_q, phase_d;
  logic signed [15:0]  prev_q, prev_d;
  logic signed [15:0]  cur_q, cur_d;
  logic signed [15:0]  buf_q, buf_d;
  logic signed [15:0]  dout_q, dout_d;
  logic                buf_full_q, buf_full_d;
  logic                cke_q, cke_d;
  logic                underrun_q, underrun_d;

  logic                tick, load, accept;
  logic signed [16:0]  diff;
  logic signed [PW-1:0] prod;
  logic signed [15:0]  interp;

  assign bus.s_ready  = !buf_full_q && !rst;
  assign bus.dout     = dout_q;
  assign bus.cke_out  = cke_q;
  assign bus.underrun = underrun_q;

  always_comb begin
    tick   = (div_cnt_q == DW'(DIV - 1));
    load   = tick && (&phase_q);
    accept = bus.s_valid && bus.s_ready;

    // Product width covers 17-bit diff times an unsigned phase, so the
    // arithmetic shift floors exactly and the sum lands between prev and cur.
    diff   = {cur_q[15], cur_q} - {prev_q[15], prev_q};
    prod   = $signed({{(PW-17){diff[16]}}, diff}) * $signed({{18{1'b0}}, phase_q});
    interp = 16'(prev_q + (prod >>> OSR_LOG2));

    div_cnt_d  = div_cnt_q + DW'(1);
    phase_d    = phase_q;
    prev_d     = prev_q;
    cur_d      = cur_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    dout_d     = dout_q;
    cke_d      = 1'b0;
    underrun_d = underrun_q;

    if (bus.underrun_clr) underrun_d = 1'b0;

    if (tick) begin
      div_cnt_d = '0;
      cke_d     = 1'b1;
      dout_d    = interp;
      phase_d   = phase_q + 1'b1;
    end

    if (load) begin
      prev_d = cur_q;
      if (buf_full_q) begin
        cur_d      = buf_q;
        buf_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end

    // accept is only possible with the buffer empty, so it never races a consume
    if (accept) begin
      buf_d      = bus.s_data;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      phase_q    <= '0;
      prev_q     <= '0;
      cur_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      dout_q     <= '0;
      cke_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      phase_q    <= phase_d;
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      dout_q     <= dout_d;
      cke_q      <= cke_d;
      underrun_q <= underrun_d;
    end
  end
endmodule

// File: tb/tb_dsm_interp.sv
// tb/tb_dsm_interp.sv - directed-vector bench for dsm_interp
module tb_dsm_interp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst1;

  dsm_interp_if if0();
  dsm_interp_if if1();

  dsm_interp #(.DIV(4), .OSR_LOG2(2)) dut  (.clk(clk), .rst(rst),  .bus(if0.slave));
  dsm_interp #(.DIV(1), .OSR_LOG2(2)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

  int vectors = 0;
  int errors  = 0;
  int cyc;
  int pops;
  int src_q[$];
  int got_q[$];

  task automatic drive();
    if (src_q.size() > 0) begin
      if0.s_valid = 1'b1;
      if0.s_data  = 16'(src_q[0]);
    end else begin
      if0.s_valid = 1'b0;
      if0.s_data  = '0;
    end
    #1;
    if (if0.s_valid && if0.s_ready) begin
      void'(src_q.pop_front());
      pops++;
    end
  endtask

  task automatic tick_cyc();
    @(posedge clk);
    #1;
    cyc++;
    if (if0.cke_out) got_q.push_back(int'(if0.dout));
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if0.underrun_clr = 1'b0;
    src_q.delete();
    drive();
    repeat (2) tick_cyc();
    rst = 1'b0;
    got_q.delete();
    cyc  = 0;
    pops = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if0.underrun_clr = 1'b0;
    src_q.delete();
    src_q.push_back(123);
    drive();
    repeat (3) tick_cyc();
    vectors += 4;
    if (if0.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %0b want 0", if0.s_ready); end
    if (if0.dout !== 16'sd0) begin errors++; $display("FAIL reset_dout got %0d want 0", if0.dout); end
    if (if0.cke_out !== 1'b0) begin errors++; $display("FAIL reset_cke got %0b want 0", if0.cke_out); end
    if (if0.underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %0b want 0", if0.underrun); end
  endtask

  task automatic test_basic();
    int exp_d[12] = '{0, 0, 0, 0, 0, 100, 200, 300, 400, 500, 600, 700};
    do_reset();
    src_q.push_back(400);
    src_q.push_back(800);
    drive();
    repeat (48) begin
      tick_cyc();
      vectors++;
      if (if0.cke_out !== ((cyc % 4) == 0)) begin
        errors++; $display("FAIL basic_cke cycle %0d got %0b want %0b", cyc, if0.cke_out, (cyc % 4) == 0);
      end
      if (cyc == 47) begin
        vectors++;
        if (if0.underrun !== 1'b0) begin errors++; $display("FAIL basic_underrun got %0b want 0", if0.underrun); end
      end
    end
    vectors++;
    if (got_q.size() != 12) begin errors++; $display("FAIL basic_count got %0d want 12", got_q.size()); end
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] != exp_d[i]) begin errors++; $display("FAIL basic_dout[%0d] got %0d want %0d", i, got_q[i], exp_d[i]); end
    end
  endtask

  task automatic test_full_scale();
    int exp_d[12] = '{0, 0, 0, 0, 0, -8192, -16384, -24576, -32768, -16385, -1, 16383};
    do_reset();
    src_q.push_back(-32768);
    src_q.push_back(32767);
    drive();
    repeat (48) tick_cyc();
    vectors++;
    if (got_q.size() != 12) begin errors++; $display("FAIL full_count got %0d want 12", got_q.size()); end
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] != exp_d[i]) begin errors++; $display("FAIL full_dout[%0d] got %0d want %0d", i, got_q[i], exp_d[i]); end
    end
  endtask

  task automatic test_neg_floor();
    int exp_d[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, -1, -2, -3};
    do_reset();
    src_q.push_back(0);
    src_q.push_back(-3);
    drive();
    repeat (48) tick_cyc();
    vectors++;
    if (got_q.size() != 12) begin errors++; $display("FAIL floor_count got %0d want 12", got_q.size()); end
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] != exp_d[i]) begin errors++; $display("FAIL floor_dout[%0d] got %0d want %0d", i, got_q[i], exp_d[i]); end
    end
  endtask

  task automatic test_underrun();
    int exp_d[12] = '{0, 0, 0, 0, 0, 125, 250, 375, 500, 500, 500, 500};
    do_reset();
    src_q.push_back(500);
    drive();
    repeat (48) begin
      tick_cyc();
      if (cyc == 31) begin
        vectors++;
        if (if0.underrun !== 1'b0) begin errors++; $display("FAIL und_before got %0b want 0", if0.underrun); end
      end
      if (cyc == 40) begin
        vectors++;
        if (if0.underrun !== 1'b1) begin errors++; $display("FAIL und_set got %0b want 1", if0.underrun); end
      end
    end
    vectors++;
    if (got_q.size() != 12) begin errors++; $display("FAIL und_count got %0d want 12", got_q.size()); end
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] != exp_d[i]) begin errors++; $display("FAIL und_dout[%0d] got %0d want %0d", i, got_q[i], exp_d[i]); end
    end
    if0.underrun_clr = 1'b1;
    tick_cyc();
    vectors++;
    if (if0.underrun !== 1'b0) begin errors++; $display("FAIL und_clr got %0b want 0", if0.underrun); end
    while (cyc < 63) tick_cyc();
    vectors++;
    if (if0.underrun !== 1'b0) begin errors++; $display("FAIL und_clr_hold got %0b want 0", if0.underrun); end
    tick_cyc();
    vectors++;
    if (if0.underrun !== 1'b1) begin errors++; $display("FAIL und_set_wins got %0b want 1", if0.underrun); end
    if0.underrun_clr = 1'b0;
    tick_cyc();
    vectors++;
    if (if0.underrun !== 1'b1) begin errors++; $display("FAIL und_sticky got %0b want 1", if0.underrun); end
  endtask

  task automatic test_back_to_back();
    int exp_d[16] = '{0, 0, 0, 0, 0, 2, 5, 7, 10, 12, 15, 17, 20, 22, 25, 27};
    do_reset();
    src_q.push_back(10);
    src_q.push_back(20);
    src_q.push_back(30);
    src_q.push_back(40);
    drive();
    repeat (64) begin
      tick_cyc();
      if (cyc == 15 || cyc == 17) begin
        vectors++;
        if (if0.s_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready cycle %0d got %0b want 0", cyc, if0.s_ready); end
      end
      if (cyc == 16) begin
        vectors++;
        if (if0.s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready cycle 16 got %0b want 1", if0.s_ready); end
      end
      if (cyc == 31) begin
        vectors++;
        if (pops != 2) begin errors++; $display("FAIL b2b_pops31 got %0d want 2", pops); end
      end
    end
    vectors++;
    if (pops != 4) begin errors++; $display("FAIL b2b_pops got %0d want 4", pops); end
    vectors++;
    if (got_q.size() != 16) begin errors++; $display("FAIL b2b_count got %0d want 16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] != exp_d[i]) begin errors++; $display("FAIL b2b_dout[%0d] got %0d want %0d", i, got_q[i], exp_d[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_q.push_back(1000);
    src_q.push_back(2000);
    drive();
    repeat (26) tick_cyc();
    vectors += 2;
    if (if0.dout !== 16'sd250) begin errors++; $display("FAIL mid_pre_dout got %0d want 250", if0.dout); end
    if (pops != 2) begin errors++; $display("FAIL mid_pre_pops got %0d want 2", pops); end
    rst = 1'b1;
    tick_cyc();
    vectors += 3;
    if (if0.dout !== 16'sd0) begin errors++; $display("FAIL mid_dout got %0d want 0", if0.dout); end
    if (if0.cke_out !== 1'b0) begin errors++; $display("FAIL mid_cke got %0b want 0", if0.cke_out); end
    if (if0.s_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %0b want 0", if0.s_ready); end
    tick_cyc();
    rst = 1'b0;
    cyc = 0;
    got_q.delete();
    drive();
    repeat (48) tick_cyc();
    vectors++;
    if (got_q.size() != 12) begin errors++; $display("FAIL mid_count got %0d want 12", got_q.size()); end
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] != 0) begin errors++; $display("FAIL mid_dropped[%0d] got %0d want 0", i, got_q[i]); end
    end
  endtask

  task automatic test_div1();
    rst1 = 1'b1;
    if1.s_valid = 1'b0;
    if1.s_data  = '0;
    repeat (2) begin @(posedge clk); #1; end
    vectors += 2;
    if (if1.cke_out !== 1'b0) begin errors++; $display("FAIL div1_reset_cke got %0b want 0", if1.cke_out); end
    if (if1.s_ready !== 1'b0) begin errors++; $display("FAIL div1_reset_ready got %0b want 0", if1.s_ready); end
    rst1 = 1'b0;
    if1.s_valid = 1'b1;
    if1.s_data  = 16'sd40;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) if1.s_valid = 1'b0;
      vectors++;
      if (if1.cke_out !== 1'b1) begin errors++; $display("FAIL div1_cke cycle %0d got %0b want 1", c, if1.cke_out); end
      if (c == 6) begin
        vectors++;
        if (if1.dout !== 16'sd10) begin errors++; $display("FAIL div1_dout6 got %0d want 10", if1.dout); end
      end
      if (c == 8) begin
        vectors++;
        if (if1.dout !== 16'sd30) begin errors++; $display("FAIL div1_dout8 got %0d want 30", if1.dout); end
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    rst1 = 1'b1;
    cyc  = 0;
    pops = 0;
    if0.s_valid = 1'b0;
    if0.s_data  = '0;
    if0.underrun_clr = 1'b0;
    if1.s_valid = 1'b0;
    if1.s_data  = '0;
    if1.underrun_clr = 1'b0;
    test_reset();
    test_basic();
    test_full_scale();
    test_neg_floor();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    test_div1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
